// File: rtl/tank_pkg.sv
// tank_pkg -- shared constants and helpers for the tank plant model.
//   LEVEL_W / SUM_W : level register width and signed update width
//   DEF_*           : default rates, thresholds and hysteresis
//   sat_level()     : clamps a signed update result into 0..255
package tank_pkg;

    localparam int LEVEL_W = 8;
    localparam int SUM_W   = 10;

    localparam int DEF_TICK_DIV    = 12;
    localparam int DEF_INFLOW_RATE = 3;
    localparam int DEF_PUMP_RATE   = 2;
    localparam int DEF_T0          = 64;
    localparam int DEF_T1          = 128;
    localparam int DEF_T2          = 192;
    localparam int DEF_HYST        = 4;

    // Clamp the signed intermediate into the level range; never wraps.
    function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SUM_W-1:0] s);
        if (s < 10'sd0) begin
            return '0;
        end else if (s > 10'sd255) begin
            return '1;
        end else begin
            return s[LEVEL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tank_model_if.sv
// tank_model_if -- bundle between a pump controller and the tank plant.
//   Y[1:0]    : pump run commands (1 = running), controller -> plant
//   INFLOW_EN : external inflow enable, controller -> plant
//   ALARM_CLR : clears sticky alarms, controller -> plant
//   X[2:0]    : thermometer-coded level sensors, plant -> controller
//   LEVEL     : current tank level, plant -> controller
//   OVERFLOW  : sticky saturation-at-top alarm, plant -> controller
//   DRY       : sticky pump-ran-dry alarm, plant -> controller
// There is no valid/ready handshake on this bundle: every signal is a
// level that the receiving side may sample at any clock edge. The plant
// only acts on Y/INFLOW_EN at tick edges and on ALARM_CLR at every edge.
interface tank_model_if;
    import tank_pkg::*;

    logic [1:0]         Y;
    logic               INFLOW_EN;
    logic               ALARM_CLR;
    logic [2:0]         X;
    logic [LEVEL_W-1:0] LEVEL;
    logic               OVERFLOW;
    logic               DRY;

    modport master (
        output Y, INFLOW_EN, ALARM_CLR,
        input  X, LEVEL, OVERFLOW, DRY
    );

    modport slave (
        input  Y, INFLOW_EN, ALARM_CLR,
        output X, LEVEL, OVERFLOW, DRY
    );

endinterface

// File: rtl/tank_model_level_sensor.sv
// level_sensor -- one hysteresis comparator with a registered output.
//   clk, rst : clock and synchronous active-high reset
//   level    : registered tank level
//   x        : sensor output; sets at level >= THRESH, clears below
//              THRESH-HYST, holds in between
module level_sensor
    import tank_pkg::*;
#(
    parameter int THRESH = DEF_T0,
    parameter int HYST   = DEF_HYST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level,
    output logic               x
);

    // One extra bit so the comparison stays unsigned and width-matched.
    localparam logic [LEVEL_W:0] SET_LVL = (LEVEL_W+1)'(THRESH);
    localparam logic [LEVEL_W:0] CLR_LVL = (LEVEL_W+1)'(THRESH - HYST);

    logic x_next;

    always_comb begin
        x_next = x;
        if ({1'b0, level} >= SET_LVL) begin
            x_next = 1'b1;
        end else if ({1'b0, level} < CLR_LVL) begin
            x_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= 1'b0;
        end else begin
            x <= x_next;
        end
    end

endmodule

// File: rtl/tank_model.sv
// tank_model -- behavioural water-tank plant for controller testing.
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : tank_model_if.slave (pump/inflow commands in, sensors/level/
//         alarms out)
// Every TICK_DIV cycles the level moves by inflow minus pumping,
// saturating at 0 and 255. Three hysteresis sensors report the level as
// a thermometer code one cycle after it changes.
module tank_model
    import tank_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int INFLOW_RATE = DEF_INFLOW_RATE,
    parameter int PUMP_RATE   = DEF_PUMP_RATE,
    parameter int T0          = DEF_T0,
    parameter int T1          = DEF_T1,
    parameter int T2          = DEF_T2,
    parameter int HYST        = DEF_HYST
) (
    input  logic         CLK,
    input  logic         RST,
    tank_model_if.slave  bus
);

    localparam logic [15:0]      TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [SUM_W-1:0] INFLOW_INC = SUM_W'(INFLOW_RATE);
    localparam logic [SUM_W-1:0] PUMP_DEC   = SUM_W'(PUMP_RATE);

    logic [15:0]              tick_cnt;
    logic                     tick;
    logic [LEVEL_W-1:0]       level_q;
    logic                     overflow_q;
    logic                     dry_q;
    logic [1:0]               pumps_on;
    logic [SUM_W-1:0]         inflow_add;
    logic [SUM_W-1:0]         pump_sub;
    logic signed [SUM_W-1:0]  sum;
    logic                     ovf_set;
    logic                     dry_set;
    logic [2:0]               x_bits;

    // The strobe fires on the cycle whose edge wraps the counter to 0, so
    // the first tick after reset lands TICK_DIV edges later.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Unsaturated update in a signed 10-bit intermediate (-4..258 with
    // default rates); the unsigned add/sub gives the same two's-complement
    // bits, reinterpreted as signed.
    always_comb begin
        pumps_on   = {1'b0, bus.Y[0]} + {1'b0, bus.Y[1]};
        inflow_add = bus.INFLOW_EN ? INFLOW_INC : '0;
        pump_sub   = SUM_W'(pumps_on) * PUMP_DEC;
        sum        = $signed({2'b00, level_q} + inflow_add - pump_sub);
        ovf_set    = tick && (sum > 10'sd255);
        dry_set    = tick && (bus.Y != 2'b00) &&
                     ((sum < 10'sd0) || (level_q == '0));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= '0;
        end else if (tick) begin
            level_q <= sat_level(sum);
        end
    end

    // Sticky alarms: a set in the same cycle as a clear takes priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q <= 1'b0;
            dry_q      <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (bus.ALARM_CLR) begin
                overflow_q <= 1'b0;
            end
            if (dry_set) begin
                dry_q <= 1'b1;
            end else if (bus.ALARM_CLR) begin
                dry_q <= 1'b0;
            end
        end
    end

    // All three sensors see the same level, and T0<T1<T2 with gaps wider
    // than HYST, so the combined output is always a thermometer code.
    level_sensor #(.THRESH(T0), .HYST(HYST)) u_sensor0 (
        .clk(CLK), .rst(RST), .level(level_q), .x(x_bits[0])
    );
    level_sensor #(.THRESH(T1), .HYST(HYST)) u_sensor1 (
        .clk(CLK), .rst(RST), .level(level_q), .x(x_bits[1])
    );
    level_sensor #(.THRESH(T2), .HYST(HYST)) u_sensor2 (
        .clk(CLK), .rst(RST), .level(level_q), .x(x_bits[2])
    );

    assign bus.X        = x_bits;
    assign bus.LEVEL    = level_q;
    assign bus.OVERFLOW = overflow_q;
    assign bus.DRY      = dry_q;

endmodule

// File: tb/tb_tank_model.sv
// tb_tank_model -- self-checking bench for tank_model.
// Two plants share the same commands: one ticking every cycle, one every
// 12 cycles. A cycle-level reference model tracks both.
module tb_tank_model;
    import tank_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] y;
    logic       inflow;
    logic       clr;

    tank_model_if bus1 ();
    tank_model_if bus12 ();

    assign bus1.Y          = y;
    assign bus1.INFLOW_EN  = inflow;
    assign bus1.ALARM_CLR  = clr;
    assign bus12.Y         = y;
    assign bus12.INFLOW_EN = inflow;
    assign bus12.ALARM_CLR = clr;

    tank_model #(.TICK_DIV(1)) dut1 (
        .CLK(clk), .RST(rst), .bus(bus1.slave)
    );
    tank_model #(.TICK_DIV(12)) dut12 (
        .CLK(clk), .RST(rst), .bus(bus12.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = plant ticking every cycle, index 1 = every 12 cycles.
    int       m_level[2];
    bit [2:0] m_x[2];
    bit       m_ov[2];
    bit       m_dry[2];
    int       m_since[2];

    function automatic int td(input int k);
        return (k == 0) ? 1 : 12;
    endfunction

    function automatic int thr(input int i);
        return (i == 0) ? DEF_T0 : (i == 1) ? DEF_T1 : DEF_T2;
    endfunction

    function automatic bit is_therm(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

    // Advances model k by one clock edge using the inputs held over it.
    task automatic model_edge(input int k);
        int       s;
        bit [2:0] nx;
        bit       ovs;
        bit       drs;
        if (rst) begin
            m_level[k] = 0;
            m_x[k]     = 3'b000;
            m_ov[k]    = 1'b0;
            m_dry[k]   = 1'b0;
            m_since[k] = 0;
            return;
        end
        m_since[k]++;
        // Sensors react to the level as it stood before this edge.
        nx = m_x[k];
        for (int i = 0; i < 3; i++) begin
            if (m_level[k] >= thr(i)) nx[i] = 1'b1;
            else if (m_level[k] < thr(i) - DEF_HYST) nx[i] = 1'b0;
        end
        ovs = 1'b0;
        drs = 1'b0;
        if (m_since[k] % td(k) == 0) begin
            s = m_level[k] + (inflow ? DEF_INFLOW_RATE : 0)
                - DEF_PUMP_RATE * (int'(y[0]) + int'(y[1]));
            ovs = (s > 255);
            drs = (y != 2'b00) && ((s < 0) || (m_level[k] == 0));
            m_level[k] = (s < 0) ? 0 : (s > 255) ? 255 : s;
        end
        m_ov[k]  = ovs ? 1'b1 : clr ? 1'b0 : m_ov[k];
        m_dry[k] = drs ? 1'b1 : clr ? 1'b0 : m_dry[k];
        m_x[k]   = nx;
    endtask

    task automatic compare_all();
        check("lvl_d1",   int'(bus1.LEVEL),    m_level[0]);
        check("x_d1",     int'(bus1.X),        int'(m_x[0]));
        check("ovf_d1",   int'(bus1.OVERFLOW), int'(m_ov[0]));
        check("dry_d1",   int'(bus1.DRY),      int'(m_dry[0]));
        check("therm_d1", int'(is_therm(bus1.X)), 1);
        check("lvl_d12",  int'(bus12.LEVEL),    m_level[1]);
        check("x_d12",    int'(bus12.X),        int'(m_x[1]));
        check("ovf_d12",  int'(bus12.OVERFLOW), int'(m_ov[1]));
        check("dry_d12",  int'(bus12.DRY),      int'(m_dry[1]));
        check("therm_d12", int'(is_therm(bus12.X)), 1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit [1:0] yy, input bit inf, input bit c);
        y      = yy;
        inflow = inf;
        clr    = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(2'b00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bias;
        rst = 1'b1;
        set_in(2'b00, 1'b0, 1'b0);
        step();
        step();
        check("rst_level", int'(bus1.LEVEL), 0);
        check("rst_x",     int'(bus1.X), 0);
        check("rst_ovf",   int'(bus1.OVERFLOW), 0);
        check("rst_dry",   int'(bus1.DRY), 0);
        rst = 1'b0;

        // Fill from empty: +3 per tick.
        set_in(2'b00, 1'b1, 1'b0);
        repeat (22) step();
        check("fill_lvl66", int'(bus1.LEVEL), 66);
        check("fill_x_pre66", int'(bus1.X), 0);
        step();
        check("fill_x001", int'(bus1.X), 1);
        repeat (20) step();
        check("fill_lvl129", int'(bus1.LEVEL), 129);
        check("fill_x_pre129", int'(bus1.X), 1);
        step();
        check("fill_x011", int'(bus1.X), 3);
        repeat (20) step();
        check("fill_lvl192", int'(bus1.LEVEL), 192);
        check("fill_x_pre192", int'(bus1.X), 3);
        step();
        check("fill_x111", int'(bus1.X), 7);

        // Hysteresis on the lowest sensor while draining with both pumps.
        do_reset();
        set_in(2'b00, 1'b1, 1'b0);
        repeat (22) step();
        set_in(2'b00, 1'b0, 1'b0);
        step();
        check("hys_lvl66", int'(bus1.LEVEL), 66);
        check("hys_x001", int'(bus1.X), 1);
        set_in(2'b11, 1'b0, 1'b0);
        step();
        check("hys_lvl62", int'(bus1.LEVEL), 62);
        check("hys_x_hold62", int'(bus1.X), 1);
        step();
        check("hys_lvl58", int'(bus1.LEVEL), 58);
        check("hys_x_hold58", int'(bus1.X), 1);
        step();
        check("hys_x000", int'(bus1.X), 0);

        // Overflow at the top, set-beats-clear, then clear while draining.
        do_reset();
        set_in(2'b00, 1'b1, 1'b0);
        repeat (84) step();
        set_in(2'b01, 1'b1, 1'b0);
        step();
        step();
        check("ovf_lvl254", int'(bus1.LEVEL), 254);
        check("ovf_pre", int'(bus1.OVERFLOW), 0);
        set_in(2'b00, 1'b1, 1'b0);
        step();
        check("ovf_lvl255", int'(bus1.LEVEL), 255);
        check("ovf_set", int'(bus1.OVERFLOW), 1);
        set_in(2'b00, 1'b1, 1'b1);
        step();
        check("ovf_set_wins", int'(bus1.OVERFLOW), 1);
        check("ovf_lvl_sat", int'(bus1.LEVEL), 255);
        set_in(2'b01, 1'b0, 1'b1);
        step();
        check("ovf_cleared", int'(bus1.OVERFLOW), 0);
        check("ovf_lvl253", int'(bus1.LEVEL), 253);

        // Pump running dry.
        do_reset();
        set_in(2'b00, 1'b1, 1'b0);
        step();
        set_in(2'b01, 1'b0, 1'b0);
        step();
        check("dry_lvl1", int'(bus1.LEVEL), 1);
        check("dry_pre", int'(bus1.DRY), 0);
        step();
        check("dry_lvl0", int'(bus1.LEVEL), 0);
        check("dry_set", int'(bus1.DRY), 1);
        set_in(2'b00, 1'b0, 1'b0);
        repeat (3) step();
        check("dry_sticky", int'(bus1.DRY), 1);
        set_in(2'b00, 1'b0, 1'b1);
        step();
        check("dry_cleared", int'(bus1.DRY), 0);

        // Reset in the middle of operation, then first-tick latency.
        do_reset();
        set_in(2'b00, 1'b1, 1'b0);
        repeat (33) step();
        set_in(2'b01, 1'b1, 1'b0);
        step();
        set_in(2'b00, 1'b0, 1'b0);
        step();
        check("mid_lvl100", int'(bus1.LEVEL), 100);
        check("mid_x001", int'(bus1.X), 1);
        rst = 1'b1;
        step();
        check("mid_rst_lvl", int'(bus1.LEVEL), 0);
        check("mid_rst_x", int'(bus1.X), 0);
        check("mid_rst_ovf", int'(bus1.OVERFLOW), 0);
        check("mid_rst_dry", int'(bus1.DRY), 0);
        rst = 1'b0;
        set_in(2'b00, 1'b1, 1'b0);
        n = 0;
        do begin
            step();
            n++;
        end while (bus12.LEVEL == '0 && n < 40);
        check("tick12_latency", n, 12);

        // Random commands, with the inflow bias drifting so the level
        // visits both rails as well as the middle.
        bias = 60;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) bias = $urandom_range(20, 95);
            rst    = ($urandom_range(0, 999) == 0);
            y      = 2'($urandom_range(0, 3));
            inflow = ($urandom_range(0, 99) < bias);
            clr    = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
